// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  // Default geometry: 64-bit words, 16 lines of one doubleword each.
  localparam int N_DEF   = 64;
  localparam int IDX_DEF = 4;
  localparam int LINES   = 2 ** IDX_DEF;
  localparam int TAGW    = N_DEF - IDX_DEF - 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_WDONE = 2'd3
  } dcache_state_t;

  // Index and tag are returned right-aligned in 64-bit fields so the
  // helper works for any index width; callers keep the low bits they need.
  typedef struct packed {
    logic [63:0] tag;
    logic [63:0] index;
  } addr_split_t;

  // Byte offset is bits [2:0]; index sits above it, tag above the index.
  function automatic addr_split_t split_addr(input logic [63:0] addr, input int idx_bits);
    addr_split_t s;
    s.index = (addr >> 3) & ((64'd1 << idx_bits) - 64'd1);
    s.tag   = addr >> (idx_bits + 3);
    return s;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the cache: combinational read, one write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDX = IDX_DEF,
  parameter int TW  = N - IDX - 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IDX-1:0] rd_index,
  output logic           rd_valid,
  output logic [TW-1:0]  rd_tag,
  output logic [N-1:0]   rd_data,
  input  logic           fill_en,
  input  logic           upd_en,
  input  logic [IDX-1:0] wr_index,
  input  logic [TW-1:0]  wr_tag,
  input  logic [N-1:0]   wr_data
);

  localparam int L = 2 ** IDX;

  logic [L-1:0]  valid_reg;
  logic [TW-1:0] tag_mem  [L];
  logic [N-1:0]  data_mem [L];

  // Valid bits: cleared together on reset, set one at a time by a fill.
  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_valid
      // Per-line valid flag.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_en && (wr_index == IDX'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag is only replaced when a whole line is filled.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // Data is written both on a fill and on a store that hits.
  always_ff @(posedge clk) begin
    if (fill_en || upd_en) begin
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// req/ack backing-memory port. Read hits never stall; misses and stores do.
module dcache
  import dcache_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDX = IDX_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_readEnable,
  input  logic         DM_writeEnable,
  output logic [N-1:0] DM_readData,
  output logic         mem_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  localparam int TW = N - IDX - 3;

  dcache_state_t  state_reg, state_next;
  addr_split_t    split;
  logic [IDX-1:0] index;
  logic [TW-1:0]  tag;
  logic           rd_valid;
  logic [TW-1:0]  rd_tag;
  logic [N-1:0]   rd_data;
  logic           hit;
  logic           fill_en, upd_en;
  logic [N-1:0]   wr_data;
  logic           issue, issue_we, req_done;
  logic           unused_bits;

  assign split = split_addr(64'(DM_addr), IDX);
  assign index = split.index[IDX-1:0];
  assign tag   = split.tag[TW-1:0];
  assign unused_bits = ^{split.index[63:IDX], split.tag[63:TW]};

  dcache_array #(.N(N), .IDX(IDX), .TW(TW)) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .fill_en  (fill_en),
    .upd_en   (upd_en),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  assign hit = rd_valid && (rd_tag == tag);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, stall, array write enables and request launch/retire.
  always_comb begin
    state_next  = state_reg;
    mem_stall   = 1'b0;
    DM_readData = rd_data;
    fill_en     = 1'b0;
    upd_en      = 1'b0;
    wr_data     = mem_rdata;
    issue       = 1'b0;
    issue_we    = 1'b0;
    req_done    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A store wins over a load when both enables are high.
        if (DM_writeEnable) begin
          mem_stall  = 1'b1;
          issue      = 1'b1;
          issue_we   = 1'b1;
          state_next = S_WRITE;
        end else if (DM_readEnable && !hit) begin
          mem_stall  = 1'b1;
          issue      = 1'b1;
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        mem_stall = 1'b1;
        if (mem_ack) begin
          fill_en    = 1'b1;
          req_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_stall = 1'b1;
        wr_data   = mem_wdata;
        if (mem_ack) begin
          // No write-allocate: only a line that already holds the address is updated.
          upd_en     = hit;
          req_done   = 1'b1;
          state_next = S_WDONE;
        end
      end
      S_WDONE: begin
        // One release cycle so the held store retires before the next access.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // While reset is asserted the pipeline must not be frozen.
    if (!reset) begin
      mem_stall   = 1'b0;
      DM_readData = '0;
    end
  end

  // Backing-memory request registers: loaded on launch, held until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req  <= 1'b1;
      mem_we   <= issue_we;
      mem_addr <= {DM_addr[N-1:3], 3'b000};
      if (issue_we) begin
        mem_wdata <= DM_writeData;
      end
    end else if (req_done) begin
      mem_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: random loads/stores against a behavioural
// cache + memory model, with a variable-latency backing-memory responder.
module tb_dcache;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr, DM_writeData, DM_readData;
  logic        DM_readEnable, DM_writeEnable;
  logic        mem_stall, mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache #(.N(64), .IDX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_readEnable  (DM_readEnable),
    .DM_writeEnable (DM_writeEnable),
    .DM_readData    (DM_readData),
    .mem_stall      (mem_stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  typedef struct {
    bit          is_store;
    logic [63:0] addr;
    logic [63:0] data;
    int          stalls;
    bit          has_req;
    logic [63:0] req_addr;
    bit          req_we;
  } exp_t;

  exp_t expq[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   ack_delay = 1;
  bit   mon_en = 1'b0;

  // Backing memory seen by the responder, and the model's own copy.
  logic [63:0] bmem      [logic [63:0]];
  logic [63:0] model_mem [logic [63:0]];
  bit          mvalid [16];
  logic [63:0] mtag   [16];
  logic [63:0] mdata  [16];

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic logic [63:0] bmem_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  function automatic logic [63:0] model_rd(input logic [63:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  endtask

  task automatic preset(input logic [63:0] a, input logic [63:0] v);
    bmem[a]      = v;
    model_mem[a] = v;
  endtask

  // Backing memory: acks in the k-th cycle of a request, noise otherwise.
  initial begin
    int cyc;
    cyc       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        cyc++;
        if (cyc == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else        mem_rdata = bmem_rd(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        cyc       = 0;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: counts stalls and requests per access, checks on retirement.
  initial begin
    int          stall_cnt, req_cnt, ntx;
    bit          in_req;
    logic [63:0] cap_addr, cap_wdata;
    logic        cap_we;
    exp_t        e;
    stall_cnt = 0; req_cnt = 0; ntx = 0; in_req = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_cnt = 0; req_cnt = 0; in_req = 1'b0;
      end else begin
        if (mem_req === 1'b1) begin
          if (!in_req) begin
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            req_cnt++;
          end else begin
            chk("req_stable_addr", mem_addr, cap_addr);
            chk("req_stable_we", 64'(mem_we), 64'(cap_we));
            chk("req_stable_wdata", mem_wdata, cap_wdata);
          end
          in_req = 1'b1;
        end else begin
          in_req = 1'b0;
        end
        if (DM_readEnable || DM_writeEnable) begin
          if (mem_stall) begin
            stall_cnt++;
          end else begin
            if (expq.size() == 0) begin
              ncmp++; nerr++;
              $display("FAIL unexpected_retire: got retirement at addr %h, expected none", DM_addr);
            end else begin
              e = expq.pop_front();
              ntx++;
              chk("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
              chk("req_count", 64'(req_cnt), 64'(e.has_req));
              if (e.has_req) begin
                chk("req_addr", cap_addr, e.req_addr);
                chk("req_we", 64'(cap_we), 64'(e.req_we));
                if (e.is_store) chk("req_wdata", cap_wdata, e.data);
              end
              if (!e.is_store) chk("load_data", DM_readData, e.data);
              $display("txn %0d: %s addr=%h data=%h stalls=%0d req=%0d",
                       ntx, e.is_store ? "ST" : "LD", e.addr,
                       e.is_store ? e.data : DM_readData, stall_cnt, req_cnt);
            end
            stall_cnt = 0; req_cnt = 0;
          end
        end else begin
          chk("idle_no_stall", 64'(mem_stall), 64'd0);
          chk("idle_no_req", 64'(mem_req), 64'd0);
        end
      end
    end
  end

  // Issue one access: predict its outcome, drive it, hold until it retires.
  task automatic do_op(input bit st, input bit rd, input logic [63:0] a,
                       input logic [63:0] d, input int k);
    exp_t        e;
    logic [63:0] al, ltag;
    int          idx, budget;
    al   = (a / 64'd8) * 64'd8;
    idx  = int'((a / 64'd8) % 64'd16);
    ltag = a / 64'd128;
    e.addr = a; e.req_addr = al;
    if (st) begin
      e.is_store = 1'b1; e.data = d; e.stalls = k + 1;
      e.has_req = 1'b1; e.req_we = 1'b1;
      model_mem[al] = d;
      if (mvalid[idx] && mtag[idx] == ltag) mdata[idx] = d;
    end else if (mvalid[idx] && mtag[idx] == ltag) begin
      e.is_store = 1'b0; e.data = mdata[idx]; e.stalls = 0;
      e.has_req = 1'b0; e.req_we = 1'b0;
    end else begin
      e.is_store = 1'b0; e.data = model_rd(al); e.stalls = k + 1;
      e.has_req = 1'b1; e.req_we = 1'b0;
      mvalid[idx] = 1'b1; mtag[idx] = ltag; mdata[idx] = e.data;
    end
    expq.push_back(e);
    ack_delay      = k;
    DM_addr        = a;
    DM_writeData   = d;
    DM_writeEnable = st;
    DM_readEnable  = rd;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (mem_stall && budget < 200);
    if (mem_stall) begin
      nerr++; ncmp++;
      $display("FAIL access_timeout: still stalled after %0d cycles, expected retirement", budget);
      summary_and_finish();
    end
    @(posedge clk); #1;
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
  endtask

  // Global time limit.
  initial begin
    #2000000;
    nerr++; ncmp++;
    $display("FAIL watchdog: simulation still running, expected completion");
    summary_and_finish();
  end

  initial begin
    logic [63:0] a, d;
    int          r;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0; mtag[i] = '0; mdata[i] = '0;
    end
    reset = 1'b0;
    DM_addr = 64'h48; DM_writeData = '0;
    DM_readEnable = 1'b1; DM_writeEnable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a load pending that would otherwise miss.
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_stall", 64'(mem_stall), 64'd0);
    chk("rst_readdata", DM_readData, 64'd0);
    DM_readEnable = 1'b0;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed sequence.
    preset(64'h40, 64'hDEAD);
    do_op(1'b0, 1'b1, 64'h40,  64'h0, 2);
    do_op(1'b0, 1'b1, 64'h40,  64'h0, 1);
    do_op(1'b0, 1'b1, 64'h47,  64'h0, 1);
    do_op(1'b1, 1'b0, 64'h40,  64'h1234, 1);
    do_op(1'b0, 1'b1, 64'h40,  64'h0, 1);
    do_op(1'b1, 1'b0, 64'h400, 64'hCAFE_F00D, 2);
    do_op(1'b0, 1'b1, 64'h400, 64'h0, 1);
    do_op(1'b0, 1'b1, 64'h440, 64'h0, 3);
    do_op(1'b0, 1'b1, 64'h40,  64'h0, 1);

    // Random phase: small tag space so hits, conflicts and store-hits occur.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = 64'($urandom_range(0, 3)) * 64'd128 + 64'($urandom_range(0, 15)) * 64'd8
          + 64'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      if (r == 0) begin
        DM_addr = a;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end else if (r <= 6) begin
        do_op(1'b0, 1'b1, a, d, $urandom_range(1, 4));
      end else if (r <= 8) begin
        do_op(1'b1, 1'b0, a, d, $urandom_range(1, 4));
      end else begin
        do_op(1'b1, 1'b1, a, d, $urandom_range(1, 4));
      end
    end

    // Reset in the middle of a fill.
    mon_en = 1'b0;
    ack_delay = 1000;
    DM_addr = 64'h0000_1000_0000_0040;
    DM_readEnable = 1'b1;
    @(negedge clk);
    chk("rt_idle_stall", 64'(mem_stall), 64'd1);
    @(negedge clk);
    chk("rt_fill_req", 64'(mem_req), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rt_req_drop", 64'(mem_req), 64'd0);
    chk("rt_stall_drop", 64'(mem_stall), 64'd0);
    chk("rt_readdata", DM_readData, 64'd0);
    chk("rt_mem_addr", mem_addr, 64'd0);
    DM_readEnable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    expq.delete();
    mon_en = 1'b1;
    do_op(1'b0, 1'b1, 64'h40, 64'h0, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drain", 64'(expq.size()), 64'd0);
    summary_and_finish();
  end

endmodule
